// File: rtl/branch_target_predictor_if.sv
// Fetch-lookup and resolve-update bus between the MIPS pipeline and the branch target predictor.
// Latency: lookup and upd_target are combinational; mispredict/redirect_pc arrive one edge after the update.
// Backpressure: none; every upd_valid cycle is consumed.
// Ports: master = pipeline (drives f_pc, upd_*), slave = predictor (drives pred_*, upd_target, mispredict, redirect_pc).
interface branch_target_predictor_if #(
   parameter int WIDTH = 32,
   parameter int OFF_W = 16
);
   logic [WIDTH-1:0] f_pc;
   logic             pred_taken;
   logic [WIDTH-1:0] pred_next_pc;
   logic             upd_valid;
   logic [WIDTH-1:0] upd_pc;
   logic [OFF_W-1:0] upd_offset;
   logic             upd_taken;
   logic             upd_pred_taken;
   logic [WIDTH-1:0] upd_pred_target;
   logic [WIDTH-1:0] upd_target;
   logic             mispredict;
   logic [WIDTH-1:0] redirect_pc;

   modport master (
      output f_pc, upd_valid, upd_pc, upd_offset, upd_taken, upd_pred_taken, upd_pred_target,
      input  pred_taken, pred_next_pc, upd_target, mispredict, redirect_pc
   );

   modport slave (
      input  f_pc, upd_valid, upd_pc, upd_offset, upd_taken, upd_pred_taken, upd_pred_target,
      output pred_taken, pred_next_pc, upd_target, mispredict, redirect_pc
   );
endinterface

// File: rtl/branch_target_predictor.sv
// Direct-mapped BTB with 2-bit saturating counters; same-cycle next-PC prediction for fetch.
// Latency: lookup 0 cycles (comb); table write and mispredict/redirect registered on the update edge.
// Backpressure: none; updates are accepted every cycle upd_valid is high.
// Ports: clk, reset_n (async, active low), bus (slave side of branch_target_predictor_if).
module branch_target_predictor #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 16,
   parameter int OFF_W = 16
) (
   input logic                   clk,
   input logic                   reset_n,
   branch_target_predictor_if.slave bus
);
   localparam int IDX   = $clog2(DEPTH);
   localparam int TAG_W = WIDTH - IDX - 2;
   localparam logic [WIDTH-1:0] PC_STEP = WIDTH'(4);

   logic             validQ  [DEPTH];
   logic [TAG_W-1:0] tagQ    [DEPTH];
   logic [WIDTH-1:0] targetQ [DEPTH];
   logic [1:0]       ctrQ    [DEPTH];

   logic [IDX-1:0]   lookIdx;
   logic [TAG_W-1:0] lookTag;
   logic             lookHit;
   logic [IDX-1:0]   updIdx;
   logic [TAG_W-1:0] updTag;
   logic             updHit;
   logic [WIDTH-1:0] offExt;
   logic [WIDTH-1:0] updTarget;
   logic [WIDTH-1:0] updPcPlus4;
   logic             mispredictQ;
   logic [WIDTH-1:0] redirectQ;

   // PC bits [1:0] are always zero for word-aligned MIPS instructions.
   logic unusedPcBits;
   assign unusedPcBits = ^{bus.f_pc[1:0], bus.upd_pc[1:0]};

   // Fetch-side lookup reads the pre-update table contents.
   assign lookIdx = bus.f_pc[IDX+1:2];
   assign lookTag = bus.f_pc[WIDTH-1:IDX+2];
   assign lookHit = validQ[lookIdx] && (tagQ[lookIdx] == lookTag);

   assign bus.pred_taken   = lookHit && ctrQ[lookIdx][1];
   assign bus.pred_next_pc = bus.pred_taken ? targetQ[lookIdx] : bus.f_pc + PC_STEP;

   // Resolve-side target: pc + 4 + (sext(offset) << 2), modulo 2^WIDTH.
   assign offExt     = {{(WIDTH-OFF_W){bus.upd_offset[OFF_W-1]}}, bus.upd_offset};
   assign updPcPlus4 = bus.upd_pc + PC_STEP;
   assign updTarget  = updPcPlus4 + (offExt << 2);
   assign bus.upd_target = updTarget;

   assign updIdx = bus.upd_pc[IDX+1:2];
   assign updTag = bus.upd_pc[WIDTH-1:IDX+2];
   assign updHit = validQ[updIdx] && (tagQ[updIdx] == updTag);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            validQ[i]  <= 1'b0;
            tagQ[i]    <= '0;
            targetQ[i] <= '0;
            ctrQ[i]    <= 2'b01;
         end
      end else if (bus.upd_valid) begin
         if (updHit) begin
            targetQ[updIdx] <= updTarget;
            if (bus.upd_taken && ctrQ[updIdx] != 2'b11)
               ctrQ[updIdx] <= ctrQ[updIdx] + 2'd1;
            else if (!bus.upd_taken && ctrQ[updIdx] != 2'b00)
               ctrQ[updIdx] <= ctrQ[updIdx] - 2'd1;
         end else if (bus.upd_taken) begin
            // Allocation overwrites whatever alias occupies the slot; starts weakly taken.
            validQ[updIdx]  <= 1'b1;
            tagQ[updIdx]    <= updTag;
            targetQ[updIdx] <= updTarget;
            ctrQ[updIdx]    <= 2'b10;
         end
      end
   end

   // A taken branch is also mispredicted when the carried target is stale.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mispredictQ <= 1'b0;
         redirectQ   <= '0;
      end else if (bus.upd_valid) begin
         mispredictQ <= (bus.upd_pred_taken != bus.upd_taken) ||
                        (bus.upd_taken && (bus.upd_pred_target != updTarget));
         redirectQ   <= bus.upd_taken ? updTarget : updPcPlus4;
      end else begin
         mispredictQ <= 1'b0;
      end
   end

   assign bus.mispredict  = mispredictQ;
   assign bus.redirect_pc = redirectQ;
endmodule

// File: tb/tb_branch_target_predictor.sv
// Directed-vector bench for branch_target_predictor with a queue-based scoreboard.
// Stimulus pushes the expected outputs for each cycle; a negedge monitor pops and compares.
module tb_branch_target_predictor;
   logic clk;
   logic reset_n;

   branch_target_predictor_if #(.WIDTH(32), .OFF_W(16)) bus ();

   branch_target_predictor #(.WIDTH(32), .DEPTH(16), .OFF_W(16)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int          id;
      logic        expT;
      logic [31:0] expN;
      logic        chkTgt;
      logic [31:0] expTgt;
      logic        expMis;
      logic [31:0] expRedir;
   } exp_t;

   exp_t expQ[$];
   int   tests = 0;
   int   fails = 0;

   task automatic chk(input string nm, input int id, input logic [31:0] act, input logic [31:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s step %0d: got 0x%08h, expected 0x%08h", nm, id, act, req);
      end
   endtask

   // Monitor: outputs are sampled mid-cycle, away from the rising edge.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (expQ.size() > 0) begin
            e = expQ.pop_front();
            chk("pred_taken",   e.id, {31'd0, bus.pred_taken}, {31'd0, e.expT});
            chk("pred_next_pc", e.id, bus.pred_next_pc, e.expN);
            if (e.chkTgt) chk("upd_target", e.id, bus.upd_target, e.expTgt);
            chk("mispredict",   e.id, {31'd0, bus.mispredict}, {31'd0, e.expMis});
            chk("redirect_pc",  e.id, bus.redirect_pc, e.expRedir);
         end
      end
   end

   // Registered expectations (expMis/expRedir) are the effect of the previous step's update.
   task automatic step(input int id, input logic [31:0] fpc, input logic expT, input logic [31:0] expN,
                       input logic uv, input logic [31:0] upc, input logic [15:0] uoff,
                       input logic ut, input logic upt, input logic [31:0] uptgt,
                       input logic [31:0] expTgt, input logic expMis, input logic [31:0] expRedir,
                       input logic rstPulse);
      exp_t e;
      @(posedge clk);
      #1;
      bus.f_pc            = fpc;
      bus.upd_valid       = uv;
      bus.upd_pc          = upc;
      bus.upd_offset      = uoff;
      bus.upd_taken       = ut;
      bus.upd_pred_taken  = upt;
      bus.upd_pred_target = uptgt;
      e.id = id; e.expT = expT; e.expN = expN; e.chkTgt = uv; e.expTgt = expTgt;
      e.expMis = expMis; e.expRedir = expRedir;
      expQ.push_back(e);
      if (rstPulse) begin
         #2 reset_n = 1'b0;
         #1 reset_n = 1'b1;
         @(negedge clk);
         #1 bus.upd_valid = 1'b0;
      end
   endtask

   initial begin
      reset_n = 1'b0;
      bus.f_pc = 32'h0; bus.upd_valid = 1'b0; bus.upd_pc = 32'h0; bus.upd_offset = 16'h0;
      bus.upd_taken = 1'b0; bus.upd_pred_taken = 1'b0; bus.upd_pred_target = 32'h0;
      #12 reset_n = 1'b1;

      //   id  f_pc         T  next          uv upc          off      t  pT pTgt          tgt           mis redir         rst
      step( 1, 32'h3000,    0, 32'h3004,     0, 32'h0,       16'h0,   0, 0, 32'h0,       32'h0,        0, 32'h0,        0);
      // allocate; same-cycle lookup still misses
      step( 2, 32'h3000,    0, 32'h3004,     1, 32'h3000,    16'h3,   1, 0, 32'h3004,    32'h3010,     0, 32'h0,        0);
      step( 3, 32'h3000,    1, 32'h3010,     0, 32'h0,       16'h0,   0, 0, 32'h0,       32'h0,        1, 32'h3010,     0);
      // counter 10 -> 11 -> 11 -> 10 -> 01
      step( 4, 32'h3000,    1, 32'h3010,     1, 32'h3000,    16'h3,   1, 1, 32'h3010,    32'h3010,     0, 32'h3010,     0);
      step( 5, 32'h3000,    1, 32'h3010,     1, 32'h3000,    16'h3,   1, 1, 32'h3010,    32'h3010,     0, 32'h3010,     0);
      step( 6, 32'h3000,    1, 32'h3010,     1, 32'h3000,    16'h3,   0, 1, 32'h3010,    32'h3010,     0, 32'h3010,     0);
      step( 7, 32'h3000,    1, 32'h3010,     1, 32'h3000,    16'h3,   0, 1, 32'h3010,    32'h3010,     1, 32'h3004,     0);
      step( 8, 32'h3000,    0, 32'h3004,     0, 32'h0,       16'h0,   0, 0, 32'h0,       32'h0,        1, 32'h3004,     0);
      // 01 -> 00 -> 00 (floor) -> 01, still predicts not-taken
      step( 9, 32'h3000,    0, 32'h3004,     1, 32'h3000,    16'h3,   0, 0, 32'h3004,    32'h3010,     0, 32'h3004,     0);
      step(10, 32'h3000,    0, 32'h3004,     1, 32'h3000,    16'h3,   0, 0, 32'h3004,    32'h3010,     0, 32'h3004,     0);
      step(11, 32'h3000,    0, 32'h3004,     1, 32'h3000,    16'h3,   1, 0, 32'h3004,    32'h3010,     0, 32'h3004,     0);
      step(12, 32'h3000,    0, 32'h3004,     0, 32'h0,       16'h0,   0, 0, 32'h0,       32'h0,        1, 32'h3010,     0);
      // negative offsets; 0x0 with -2 words wraps and evicts 0x3000 (same index)
      step(13, 32'h3008,    0, 32'h300C,     1, 32'h3008,    16'hFFFF,0, 0, 32'h300C,    32'h3008,     0, 32'h3010,     0);
      step(14, 32'h3008,    0, 32'h300C,     1, 32'h0,       16'hFFFE,1, 0, 32'h4,       32'hFFFFFFFC, 0, 32'h300C,     0);
      step(15, 32'h0,       1, 32'hFFFFFFFC, 0, 32'h0,       16'h0,   0, 0, 32'h0,       32'h0,        1, 32'hFFFFFFFC, 0);
      // re-allocate 0x3000, then alias 0x3040 misses and evicts it
      step(16, 32'h3000,    0, 32'h3004,     1, 32'h3000,    16'h3,   1, 0, 32'h3004,    32'h3010,     0, 32'hFFFFFFFC, 0);
      step(17, 32'h3040,    0, 32'h3044,     1, 32'h3040,    16'h10,  1, 0, 32'h3044,    32'h3084,     1, 32'h3010,     0);
      step(18, 32'h3000,    0, 32'h3004,     0, 32'h0,       16'h0,   0, 0, 32'h0,       32'h0,        1, 32'h3084,     0);
      step(19, 32'h3040,    1, 32'h3084,     0, 32'h0,       16'h0,   0, 0, 32'h0,       32'h0,        0, 32'h3084,     0);
      // direction right but carried target wrong
      step(20, 32'h3040,    1, 32'h3084,     1, 32'h3040,    16'h10,  1, 1, 32'h3088,    32'h3084,     0, 32'h3084,     0);
      // async reset pulse mid-cycle during an update; no clock edge before the check
      step(21, 32'h3040,    0, 32'h3044,     1, 32'h3044,    16'h0,   1, 0, 32'h3048,    32'h3048,     0, 32'h0,        1);
      step(22, 32'h3044,    0, 32'h3048,     0, 32'h0,       16'h0,   0, 0, 32'h0,       32'h0,        0, 32'h0,        0);
      step(23, 32'h3040,    0, 32'h3044,     0, 32'h0,       16'h0,   0, 0, 32'h0,       32'h0,        0, 32'h0,        0);

      @(posedge clk);
      @(negedge clk);
      #1;
      chk("scoreboard_drain", 0, expQ.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
